// File: rtl/verisc_pkg.sv
// Shared VeriRISC definitions: default bus widths, opcode constants and the
// memory responder state encoding.
package verisc_pkg;

    localparam int VERISC_AWIDTH = 5;
    localparam int VERISC_DWIDTH = 8;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/verisc_mem_array.sv
// Word store with asynchronous clear, preload-over-bus write muxing per word
// and a combinational read port (the caller registers the read data).
module verisc_mem_array
    import verisc_pkg::*;
#(
    parameter int AWIDTH = VERISC_AWIDTH,
    parameter int DWIDTH = VERISC_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_we,
    input  logic [AWIDTH-1:0] bus_addr,
    input  logic [DWIDTH-1:0] bus_data,
    input  logic              init_we,
    input  logic [AWIDTH-1:0] init_addr,
    input  logic [DWIDTH-1:0] init_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_word
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Preload wins only on the word it targets; a bus write elsewhere still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (init_we && init_addr == AWIDTH'(i)) begin
                    mem[i] <= init_data;
                end else if (bus_we && bus_addr == AWIDTH'(i)) begin
                    mem[i] <= bus_data;
                end
            end
        end
    end

    assign rd_word = mem[rd_addr];

endmodule

// File: rtl/verisc_bus_memory.sv
// VeriRISC bus-side memory responder: one write per wr strobe, registered reads,
// sticky protocol-error flag. Optional write protection via MEM_WR_PROTECT_EN.
module verisc_bus_memory
    import verisc_pkg::*;
#(
    parameter int AWIDTH    = VERISC_AWIDTH,
    parameter int DWIDTH    = VERISC_DWIDTH,
    parameter int PROT_BASE = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd,
    input  logic              wr,
    input  logic              data_e,
    input  logic              init_we,
    input  logic [AWIDTH-1:0] init_addr,
    input  logic [DWIDTH-1:0] init_data,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              bus_err
);

`ifdef MEM_WR_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    localparam logic [AWIDTH:0] PROT_LIM = (AWIDTH + 1)'(PROT_BASE);

    mem_state_t        state;
    logic [DWIDTH-1:0] rd_word;
    logic              prot_hit;
    logic              first_wr;
    logic              bus_we;

    assign prot_hit = PROT_EN && ({1'b0, addr} >= PROT_LIM);
    assign first_wr = wr && !rd && data_e && (state != MEM_WRITE);
    assign bus_we   = first_wr && !prot_hit;

    verisc_mem_array #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .bus_we    (bus_we),
        .bus_addr  (addr),
        .bus_data  (wr_data),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .rd_addr   (addr),
        .rd_word   (rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MEM_IDLE;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (rd && wr) begin
                bus_err  <= 1'b1;
                rd_valid <= 1'b0;
                state    <= MEM_IDLE;
            end else if (rd) begin
                rd_data  <= rd_word;
                rd_valid <= 1'b1;
                state    <= MEM_READ;
            end else if (wr) begin
                rd_valid <= 1'b0;
                if (!data_e) begin
                    bus_err <= 1'b1;
                end else if (state != MEM_WRITE) begin
                    // The strobe is consumed even when protection drops the write.
                    if (prot_hit) begin
                        bus_err <= 1'b1;
                    end
                    state <= MEM_WRITE;
                end
            end else begin
                rd_valid <= 1'b0;
                state    <= MEM_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_verisc_bus_memory.sv
// Scoreboard bench for verisc_bus_memory: reads push expected data, a negedge
// monitor pops and compares whenever rd_valid is high.
module tb_verisc_bus_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic       data_e = 1'b0;
    logic       init_we = 1'b0;
    logic [4:0] init_addr = '0;
    logic [7:0] init_data = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       bus_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    verisc_bus_memory dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd        (rd),
        .wr        (wr),
        .data_e    (data_e),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got %h with no expected entry", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL read_data got %h expected %h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        rd = 1'b0; wr = 1'b0; data_e = 1'b0; init_we = 1'b0;
        tick();
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        init_we = 1'b1; init_addr = a; init_data = d;
        tick();
        init_we = 1'b0;
    endtask

    task automatic read_one(input logic [4:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        rd = 1'b1; wr = 1'b0; addr = a;
        tick();
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_rd_valid", {7'b0, rd_valid}, 8'h00);
        check("reset_bus_err", {7'b0, bus_err}, 8'h00);
        rst = 1'b0;
        idle_cycle();

        // Preload then read, including an address change while rd is held.
        preload(5'd3, 8'hA5);
        read_one(5'd3, 8'hA5);
        read_one(5'd0, 8'h00);
        idle_cycle();
        check("rd_valid_drop", {7'b0, rd_valid}, 8'h00);
        check("rd_data_hold", rd_data, 8'h00);

        // Held write strobe commits only the first cycle's data.
        wr = 1'b1; data_e = 1'b1; addr = 5'd7; wr_data = 8'h3C;
        tick();
        wr_data = 8'h00;
        tick();
        tick();
        idle_cycle();
        read_one(5'd7, 8'h3C);
        idle_cycle();
        check("write_hold_no_err", {7'b0, bus_err}, 8'h00);

        // Preload beats a same-cycle bus write; same-cycle read sees old data.
        init_we = 1'b1; init_addr = 5'd9; init_data = 8'h44;
        wr = 1'b1; data_e = 1'b1; addr = 5'd9; wr_data = 8'h55;
        tick();
        idle_cycle();
        init_we = 1'b1; init_addr = 5'd9; init_data = 8'h66;
        read_one(5'd9, 8'h44);
        init_we = 1'b0;
        read_one(5'd9, 8'h66);
        idle_cycle();
        check("preload_prio_no_err", {7'b0, bus_err}, 8'h00);

        // Write without data_e.
        preload(5'd2, 8'h5A);
        wr = 1'b1; data_e = 1'b0; addr = 5'd2; wr_data = 8'h77;
        tick();
        check("no_data_e_err", {7'b0, bus_err}, 8'h01);
        idle_cycle();
        read_one(5'd2, 8'h5A);
        idle_cycle();
        idle_cycle();
        check("bus_err_sticky", {7'b0, bus_err}, 8'h01);

        rst_pulse();
        check("err_cleared", {7'b0, bus_err}, 8'h00);
        check("rd_data_cleared", rd_data, 8'h00);
        read_one(5'd3, 8'h00);
        idle_cycle();

        // rd and wr together.
        preload(5'd3, 8'hA5);
        read_one(5'd3, 8'hA5);
        wr = 1'b1; data_e = 1'b1; wr_data = 8'h99; addr = 5'd3;
        tick();
        check("rdwr_err", {7'b0, bus_err}, 8'h01);
        check("rdwr_valid", {7'b0, rd_valid}, 8'h00);
        check("rdwr_data_kept", rd_data, 8'hA5);
        idle_cycle();
        read_one(5'd3, 8'hA5);
        idle_cycle();

        // Write to the top of the map (protected only with MEM_WR_PROTECT_EN).
        rst_pulse();
        preload(5'd30, 8'h12);
        wr = 1'b1; data_e = 1'b1; addr = 5'd30; wr_data = 8'hFF;
        tick();
        idle_cycle();
`ifdef MEM_WR_PROTECT_EN
        read_one(5'd30, 8'h12);
        idle_cycle();
        check("prot_err", {7'b0, bus_err}, 8'h01);
`else
        read_one(5'd30, 8'hFF);
        idle_cycle();
        check("unprot_no_err", {7'b0, bus_err}, 8'h00);
`endif
        preload(5'd30, 8'h34);
        read_one(5'd30, 8'h34);
        idle_cycle();

        // Reset in the middle of a held read.
        preload(5'd1, 8'h11);
        read_one(5'd1, 8'h11);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_rd_data", rd_data, 8'h00);
        check("midrst_rd_valid", {7'b0, rd_valid}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd = 1'b0;
        tick();
        read_one(5'd1, 8'h00);
        idle_cycle();
        idle_cycle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads got %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
